// File: rtl/div6by3_seq.sv
// ---------------------------------------------------------------------------
// div6by3_seq -- sequential 6-bit by 3-bit unsigned restoring divider
//
// Divides a 6-bit dividend N by a 3-bit divisor D, producing one quotient bit
// per clock, MSB first, from a 4-bit partial remainder. An operation is
// requested with start in IDLE. It runs for six RUN cycles, then spends one
// cycle in DONE, where done pulses and the results become valid.
//
// Optional feature macro: DIV_ZERO_FLAG_EN
//   When defined, a start with D=0 goes straight from IDLE to DONE. The
//   div_zero port is then present and pulses together with done.
//   When undefined, D=0 runs the normal six iterations and returns Q=63, R=0.
//
// Ports
//   clk        in   1  rising-edge clock for all state
//   rst        in   1  synchronous active-high reset
//   start      in   1  division request, sampled only in IDLE
//   dividend   in   6  unsigned dividend N
//   divisor    in   3  unsigned divisor D
//   quotient   out  6  Q = N / D, held until the next completed operation
//   remainder  out  3  R = N mod D, held until the next completed operation
//   busy       out  1  high in RUN and DONE
//   done       out  1  one-cycle pulse in DONE, results valid
//   div_zero   out  1  divide-by-zero pulse (only with DIV_ZERO_FLAG_EN)
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; operands are latched on the leaving edge
// RUN    | one shift/subtract iteration per edge, six edges in total
// DONE   | done pulses for one cycle; always returns to IDLE
// ---------------------------------------------------------------------------
module div6by3_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] dividend,
  input  logic [2:0] divisor,
  output logic [5:0] quotient,
  output logic [2:0] remainder,
  output logic       busy,
  output logic       done
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic       div_zero
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ITER = 3'd5;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] n_q, n_d;           // dividend, shifted left one bit per iteration
  logic [2:0] d_q, d_d;           // latched divisor
  logic [3:0] rem_q, rem_d;       // partial remainder
  logic [4:0] qacc_q, qacc_d;     // quotient bits collected so far
  logic [5:0] quotient_q, quotient_d;
  logic [2:0] remainder_q, remainder_d;

`ifdef DIV_ZERO_FLAG_EN
  logic       dz_q, dz_d;
`endif

  logic [3:0] trial;
  logic       trial_ge;
  logic [3:0] rem_step;
  logic       q_bit;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract D when it fits. rem_q[3] can only be set when D=0
  // (otherwise the remainder stays below D <= 7), and then the shifted value
  // is at least 16, so treating it as "fits" keeps the step consistent.
  always_comb begin
    trial    = {rem_q[2:0], n_q[5]};
    trial_ge = rem_q[3] | (trial >= {1'b0, d_q});
    rem_step = trial_ge ? (trial - {1'b0, d_q}) : trial;
    q_bit    = trial_ge;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    d_d         = d_q;
    rem_d       = rem_q;
    qacc_d      = qacc_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_FLAG_EN
    dz_d        = dz_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = dividend;
          d_d     = divisor;
          cnt_d   = 3'd0;
          rem_d   = 4'd0;
          qacc_d  = 5'd0;
          state_d = S_RUN;
`ifdef DIV_ZERO_FLAG_EN
          dz_d    = 1'b0;
          if (divisor == 3'd0) begin
            // Early exit: the result is fixed, so skip the iterations.
            state_d     = S_DONE;
            quotient_d  = 6'h3f;
            remainder_d = 3'd0;
            dz_d        = 1'b1;
          end
`endif
        end
      end

      S_RUN: begin
        n_d    = {n_q[4:0], 1'b0};
        rem_d  = rem_step;
        qacc_d = {qacc_q[3:0], q_bit};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == LAST_ITER) begin
          state_d    = S_DONE;
          quotient_d = {qacc_q, q_bit};
          // D=0 naturally yields all-ones quotient bits; the remainder is
          // forced to 0 because the partial remainder has overflowed.
          remainder_d = (d_q == 3'd0) ? 3'd0 : rem_step[2:0];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 6'd0;
      d_q         <= 3'd0;
      rem_q       <= 4'd0;
      qacc_q      <= 5'd0;
      quotient_q  <= 6'd0;
      remainder_q <= 3'd0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      d_q         <= d_d;
      rem_q       <= rem_d;
      qacc_q      <= qacc_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_ZERO_FLAG_EN
      dz_q        <= dz_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
`ifdef DIV_ZERO_FLAG_EN
  // dz_q stays set after the pulse; gating with DONE keeps it a pulse.
  assign div_zero  = dz_q & (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_div6by3_seq.sv
// ---------------------------------------------------------------------------
// tb_div6by3_seq -- self-checking bench for div6by3_seq.
// Expected results come from plain integer division; latency is counted in
// clock edges after the edge that samples start.
// ---------------------------------------------------------------------------
module tb_div6by3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       busy;
  logic       done;
`ifdef DIV_ZERO_FLAG_EN
  logic       div_zero;
`endif

  int checks   = 0;
  int failures = 0;

  div6by3_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_q(input int n, input int d);
    return (d == 0) ? 63 : n / d;
  endfunction

  function automatic int ref_r(input int n, input int d);
    return (d == 0) ? 0 : n % d;
  endfunction

  function automatic int ref_lat(input int d);
`ifdef DIV_ZERO_FLAG_EN
    return (d == 0) ? 0 : 6;
`else
    return 6;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge with the DUT idle; the next edge samples start.
  task automatic do_op(input int n, input int d, input bit scramble);
    int lat;
    start    = 1'b1;
    dividend = 6'(n);
    divisor  = 3'(d);
    tick();
    start = 1'b0;
    if (scramble) begin
      dividend = 6'($urandom);
      divisor  = 3'($urandom);
    end
    lat = 0;
    while (!done && lat < 12) begin
      chk("busy_in_run", int'(busy), 1);
      tick();
      lat++;
    end
    chk("latency", lat, ref_lat(d));
    chk("quotient", int'(quotient), ref_q(n, d));
    chk("remainder", int'(remainder), ref_r(n, d));
    chk("busy_in_done", int'(busy), 1);
`ifdef DIV_ZERO_FLAG_EN
    chk("div_zero", int'(div_zero), (d == 0) ? 1 : 0);
`endif
    tick();
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    chk("quotient_hold", int'(quotient), ref_q(n, d));
    chk("remainder_hold", int'(remainder), ref_r(n, d));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int last_e;
    int e;

    // Reset with start held high: start on a reset edge must be ignored.
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 6'd45;
    divisor  = 3'd6;
    tick();
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
`ifdef DIV_ZERO_FLAG_EN
    chk("rst_div_zero", int'(div_zero), 0);
`endif
    start = 1'b0;
    rst   = 1'b0;
    tick();
    chk("idle_after_rst", int'(busy), 0);

    // Directed cases, including boundaries.
    do_op(45, 6, 1'b1);
    do_op(63, 7, 1'b0);
    do_op(5, 7, 1'b1);
    do_op(0, 1, 1'b0);
    do_op(63, 1, 1'b1);
    do_op(37, 0, 1'b0);

    // start held high: a new operation every 8 edges; mid-run input changes
    // must not disturb the operation in flight.
    start    = 1'b1;
    dividend = 6'd20;
    divisor  = 3'd3;
    pulses   = 0;
    last_e   = 1;
    for (e = 1; e <= 26; e++) begin
      tick();
      if (done) begin
        pulses++;
        chk("held_period", e - last_e, (pulses == 1) ? 6 : 8);
        chk("held_quotient", int'(quotient), 6);
        chk("held_remainder", int'(remainder), 2);
        last_e   = e;
        dividend = 6'd20;
        divisor  = 3'd3;
      end else if (busy) begin
        dividend = 6'($urandom);
        divisor  = 3'($urandom);
      end
    end
    chk("held_pulses", pulses, 3);
    start = 1'b0;
    e = 0;
    while (busy && e < 20) begin
      tick();
      e++;
    end
    chk("held_drain", int'(busy), 0);

    // Abort: reset sampled at the end of the third RUN cycle.
    start    = 1'b1;
    dividend = 6'd50;
    divisor  = 3'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    do_op(50, 5, 1'b0);

    // Exhaustive sweep of all nonzero divisors.
    for (int d = 1; d < 8; d++) begin
      for (int n = 0; n < 64; n++) begin
        do_op(n, d, n[0]);
      end
    end

    // Random operations, divide-by-zero included.
    for (int i = 0; i < 60; i++) begin
      do_op(int'($urandom_range(63, 0)), int'($urandom_range(7, 0)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
